citron_bus_arbiter: RTL

Round-robin arbiter that shares the single Citron device bus (8-bit word address, 32-bit data, rdy/wr/stall/match) among `N_REQ` requesters, e.g. the AXI slave bridge and a debug or DMA master. It serialises one access at a time and generates the one-cycle `citron_rdy` strobe. For reads it waits out device stall, then returns read data plus a no-match error to the granted requester. It sits between the requesters and the OR-combined Citron device outputs.

---
 rtl/citron_pkg.sv | 20 ++
 rtl/citron_rr_picker.sv | 46 ++++
 rtl/citron_bus_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/citron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : citron_pkg
//  Description : Shared types and constants for the Citron bus arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package citron_pkg;

   localparam int CITRON_ADDR_W = 8;
   localparam int CITRON_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } citron_arb_state_t;

endpackage : citron_pkg
`default_nettype wire

// File: rtl/citron_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : citron_rr_picker
//  Description : Combinational round-robin winner search. The search starts
//                at requester rr_i and wraps, so the first active request at
//                or after the pointer wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module citron_rr_picker #(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] rr_i,
   output logic [N_REQ-1:0]         win_oh_o,
   output logic [$clog2(N_REQ)-1:0] win_idx_o,
   output logic                     win_vld_o
);

   localparam int c_idx_w = $clog2(N_REQ);

   int                 w_sum;
   logic [c_idx_w-1:0] w_k;

   // Walk the requesters in rotated order and keep the first one found.
   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      win_vld_o = 1'b0;
      w_sum     = 0;
      w_k       = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = int'(rr_i) + i;
         if (w_sum >= N_REQ) begin
            w_sum = w_sum - N_REQ;
         end
         w_k = c_idx_w'(w_sum);
         if (!win_vld_o && req_i[w_k]) begin
            win_vld_o     = 1'b1;
            win_oh_o[w_k] = 1'b1;
            win_idx_o     = w_k;
         end
      end
   end

endmodule : citron_rr_picker
`default_nettype wire

// File: rtl/citron_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : citron_bus_arbiter
//  Description : Round-robin arbiter sharing the Citron device bus among
//                N_REQ requesters. One access at a time: IDLE picks a winner,
//                ISSUE strobes citron_rdy, WAIT rides out device stall, DONE
//                returns read data / no-match error and advances the pointer.
//                Optional stall watchdog: define CITRON_ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module citron_bus_arbiter
   import citron_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [N_REQ-1:0]                 req_i,
   input  logic [N_REQ-1:0]                 wr_i,
   input  logic [N_REQ*CITRON_ADDR_W-1:0]   addr_i,
   input  logic [N_REQ*CITRON_DATA_W-1:0]   wdata_i,
   output logic [N_REQ-1:0]                 gnt_o,
   output logic [N_REQ-1:0]                 done_o,
   output logic [CITRON_DATA_W-1:0]         rdata_o,
   output logic                             err_o,
   output logic [CITRON_ADDR_W-1:0]         citron_addr_o,
   output logic                             citron_rdy_o,
   output logic                             citron_wr_o,
   output logic [CITRON_DATA_W-1:0]         citron_writedata_o,
   input  logic [CITRON_DATA_W-1:0]         citron_readdata_i,
   input  logic                             citron_stall_i,
   input  logic                             citron_match_i
);

   localparam int                 c_idx_w    = $clog2(N_REQ);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_REQ - 1);

   citron_arb_state_t r_state, w_state_nxt;

   logic [N_REQ-1:0]         w_win_oh;
   logic [c_idx_w-1:0]       w_win_idx;
   logic                     w_win_vld;
   logic                     w_complete;
   logic                     w_timeout;
   logic                     w_busy;

   logic [c_idx_w-1:0]       r_rr;
   logic [c_idx_w-1:0]       r_gidx;
   logic [N_REQ-1:0]         r_gnt_oh;
   logic                     r_wr;
   logic [CITRON_ADDR_W-1:0] r_addr;
   logic [CITRON_DATA_W-1:0] r_wdata;
   logic [CITRON_DATA_W-1:0] r_rdata;
   logic                     r_err;

   citron_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req_i     (req_i),
      .rr_i      (r_rr),
      .win_oh_o  (w_win_oh),
      .win_idx_o (w_win_idx),
      .win_vld_o (w_win_vld)
   );

   // A write finishes on its first WAIT cycle; a read waits for stall to drop.
   assign w_complete = (r_state == ST_WAIT) && (r_wr || !citron_stall_i);

`ifdef CITRON_ARB_TIMEOUT_EN
   localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_wait_cnt;

   // Count WAIT cycles; cleared during ISSUE so it starts at zero on WAIT entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_ISSUE) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   // The TIMEOUT_CYCLES-th stalled WAIT cycle gives up on the device.
   assign w_timeout = (r_state == ST_WAIT) && !w_complete && (r_wait_cnt == c_cnt_last);
`else
   logic w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_win_vld) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (w_complete || w_timeout) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Latch the winner's request, capture the completion, advance the pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr     <= '0;
         r_gidx   <= '0;
         r_gnt_oh <= '0;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && w_win_vld) begin
            r_gidx   <= w_win_idx;
            r_gnt_oh <= w_win_oh;
            r_wr     <= wr_i[w_win_idx];
            r_addr   <= addr_i[int'(w_win_idx)*CITRON_ADDR_W +: CITRON_ADDR_W];
            r_wdata  <= wdata_i[int'(w_win_idx)*CITRON_DATA_W +: CITRON_DATA_W];
         end
         if (w_complete) begin
            r_rdata <= r_wr ? '0 : citron_readdata_i;
            r_err   <= ~citron_match_i;
         end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
         end
         if (r_state == ST_DONE) begin
            r_rr <= (r_gidx == c_last_idx) ? '0 : r_gidx + 1'b1;
         end
      end
   end

   // Outputs decode straight from registered state, so reset clears them at once.
   assign w_busy             = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign gnt_o              = (r_state == ST_ISSUE) ? r_gnt_oh : '0;
   assign done_o             = (r_state == ST_DONE)  ? r_gnt_oh : '0;
   assign rdata_o            = (r_state == ST_DONE)  ? r_rdata  : '0;
   assign err_o              = (r_state == ST_DONE)  && r_err;
   assign citron_rdy_o       = (r_state == ST_ISSUE);
   assign citron_addr_o      = w_busy ? r_addr  : '0;
   assign citron_wr_o        = w_busy && r_wr;
   assign citron_writedata_o = w_busy ? r_wdata : '0;

endmodule : citron_bus_arbiter
`default_nettype wire
